// File: rtl/serial_demux_buf.sv
// Bit-serial packet receiver that routes each payload into one of N_CH shift FIFOs.
// Optional even parity on each packet: define SERIAL_DEMUX_PARITY_EN.
module serial_demux_buf #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 2,
   parameter int DEPTH  = 6
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          start,
   input  logic                                          key0,
   input  logic                                          key1,
   input  logic                                          rd_en,
   input  logic [ADDR_W-1:0]                             rd_ch,
   output logic [DATA_W-1:0]                             rd_data,
   output logic                                          rd_valid,
   output logic [(2**ADDR_W)*DEPTH*(DATA_W+1)-1:0]       buf_o,
   output logic [(2**ADDR_W)*$clog2(DEPTH+1)-1:0]        count_o,
   output logic                                          busy_o,
   output logic                                          ovf_o,
   output logic                                          err_o
);

   localparam int unsigned N_CH = 2**ADDR_W;
   localparam int unsigned CW   = $clog2(DEPTH+1);
   localparam int unsigned SW   = DATA_W + 1;
`ifdef SERIAL_DEMUX_PARITY_EN
   localparam int unsigned P    = ADDR_W + DATA_W + 1;
`else
   localparam int unsigned P    = ADDR_W + DATA_W;
`endif
   localparam int unsigned BW   = $clog2(P+1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RECV = 2'd1;
   localparam logic [1:0] S_DISP = 2'd2;

   logic [1:0]        state;
   logic [P-1:0]      pkt;
   logic [BW-1:0]     bcnt;
   logic              bit_v;
   logic [ADDR_W-1:0] wr_ch;
   logic [DATA_W-1:0] wr_data;
   logic              par_ok;
   logic              wr_en;

   logic [SW-1:0]     slot_q [N_CH][DEPTH];
   logic [SW-1:0]     slot_n [N_CH][DEPTH];
   logic [CW-1:0]     cnt_q  [N_CH];
   logic [CW-1:0]     cnt_n  [N_CH];
   logic              ovf_n;
   logic              pop_ok;
   logic [DATA_W-1:0] pop_data;

   assign bit_v   = key0 ^ key1;
   assign wr_ch   = pkt[P-1 -: ADDR_W];
   assign wr_data = pkt[P-1-ADDR_W -: DATA_W];
`ifdef SERIAL_DEMUX_PARITY_EN
   assign par_ok  = ~(^pkt);
`else
   assign par_ok  = 1'b1;
`endif
   assign wr_en   = (state == S_DISP) && par_ok;
   assign busy_o  = (state != S_IDLE);

   // Packet assembly: MSB-first shift, restart on start, one DISPATCH cycle per packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         pkt   <= '0;
         bcnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RECV;
                  pkt   <= '0;
                  bcnt  <= '0;
               end
            end
            S_RECV: begin
               if (start) begin
                  pkt  <= '0;
                  bcnt <= '0;
               end else if (bit_v) begin
                  pkt  <= {pkt[P-2:0], key1};
                  bcnt <= bcnt + 1'b1;
                  if (bcnt == BW'(P-1))
                     state <= S_DISP;
               end
            end
            S_DISP: begin
               if (start) begin
                  state <= S_RECV;
                  pkt   <= '0;
                  bcnt  <= '0;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Per-channel next state: the pop is applied first so a same-cycle append never overflows.
   always_comb begin
      slot_n = slot_q;
      cnt_n  = cnt_q;
      ovf_n  = 1'b0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         if (rd_en && (rd_ch == ADDR_W'(c)) && (cnt_q[c] != '0)) begin
            for (int unsigned s = 0; s < DEPTH-1; s++)
               slot_n[c][s] = slot_n[c][s+1];
            slot_n[c][DEPTH-1] = '0;
            cnt_n[c] = cnt_n[c] - 1'b1;
         end
         if (wr_en && (wr_ch == ADDR_W'(c))) begin
            if (cnt_n[c] == CW'(DEPTH)) begin
               for (int unsigned s = 0; s < DEPTH-1; s++)
                  slot_n[c][s] = slot_n[c][s+1];
               slot_n[c][DEPTH-1] = {wr_data, 1'b1};
               ovf_n = 1'b1;
            end else begin
               for (int unsigned s = 0; s < DEPTH; s++)
                  if (CW'(s) == cnt_n[c])
                     slot_n[c][s] = {wr_data, 1'b1};
               cnt_n[c] = cnt_n[c] + 1'b1;
            end
         end
      end
   end

   assign pop_ok   = rd_en && (cnt_q[rd_ch] != '0);
   assign pop_data = slot_q[rd_ch][0][SW-1:1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < N_CH; c++) begin
            cnt_q[c] <= '0;
            for (int unsigned s = 0; s < DEPTH; s++)
               slot_q[c][s] <= '0;
         end
         rd_data  <= '0;
         rd_valid <= 1'b0;
         ovf_o    <= 1'b0;
      end else begin
         slot_q   <= slot_n;
         cnt_q    <= cnt_n;
         ovf_o    <= ovf_n;
         rd_valid <= pop_ok;
         if (pop_ok)
            rd_data <= pop_data;
      end
   end

`ifdef SERIAL_DEMUX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_o <= 1'b0;
      else
         err_o <= (state == S_DISP) && !par_ok;
   end
`else
   assign err_o = 1'b0;
`endif

   always_comb begin
      buf_o   = '0;
      count_o = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         count_o[c*CW +: CW] = cnt_q[c];
         for (int unsigned s = 0; s < DEPTH; s++)
            buf_o[(c*DEPTH+s)*SW +: SW] = slot_q[c][s];
      end
   end

endmodule

// File: tb/tb_serial_demux_buf.sv
// Scoreboard bench for serial_demux_buf (default parameters); parity cases run when
// SERIAL_DEMUX_PARITY_EN is defined.
module tb_serial_demux_buf;

   localparam int ADDR_W = 2;
   localparam int DATA_W = 2;
   localparam int DEPTH  = 6;
`ifdef SERIAL_DEMUX_PARITY_EN
   localparam int PB = 5;
`else
   localparam int PB = 4;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        key0 = 1'b0;
   logic        key1 = 1'b0;
   logic        rd_en = 1'b0;
   logic [1:0]  rd_ch = '0;
   logic [1:0]  rd_data;
   logic        rd_valid;
   logic [71:0] buf_o;
   logic [11:0] count_o;
   logic        busy_o;
   logic        ovf_o;
   logic        err_o;

   serial_demux_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key0(key0), .key1(key1),
      .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
      .buf_o(buf_o), .count_o(count_o), .busy_o(busy_o), .ovf_o(ovf_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   logic [1:0] exp_q[$];
   int m_d[4][6];
   int m_n[4];
   int ovf_exp  = 0;
   int ovf_seen = 0;
   bit last_ovf;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every rd_valid pulse must match the oldest expected pop.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL rd_unexpected: got rd_valid=1 data %0h expected no pop", rd_data);
            end else begin
               check("rd_data", 128'(rd_data), 128'(exp_q.pop_front()));
            end
         end
         if (ovf_o) ovf_seen++;
      end
   end

   function automatic bit m_write(input int c, input int d);
      bit o = 1'b0;
      if (m_n[c] == DEPTH) begin
         for (int s = 0; s < DEPTH-1; s++) m_d[c][s] = m_d[c][s+1];
         m_d[c][DEPTH-1] = d;
         o = 1'b1;
      end else begin
         m_d[c][m_n[c]] = d;
         m_n[c]++;
      end
      return o;
   endfunction

   function automatic void m_pop(input int c);
      for (int s = 0; s < DEPTH-1; s++) m_d[c][s] = m_d[c][s+1];
      m_n[c]--;
   endfunction

   function automatic logic [71:0] m_img();
      logic [71:0] img = '0;
      for (int c = 0; c < 4; c++)
         for (int s = 0; s < m_n[c]; s++)
            img[(c*DEPTH+s)*3 +: 3] = {2'(m_d[c][s]), 1'b1};
      return img;
   endfunction

   function automatic logic [11:0] m_cnt();
      logic [11:0] v = '0;
      for (int c = 0; c < 4; c++) v[c*3 +: 3] = 3'(m_n[c]);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input bit b);
      key0 = ~b;
      key1 = b;
      tick();
      key0 = 1'b0;
      key1 = 1'b0;
   endtask

   task automatic check_image(input string tag);
      check({tag, "_buf"}, 128'(buf_o), 128'(m_img()));
      check({tag, "_cnt"}, 128'(count_o), 128'(m_cnt()));
   endtask

   task automatic send_pkt(input int a, input int d, input bit bad, input bit pop_disp, input int pch);
      logic [PB-1:0] v;
`ifdef SERIAL_DEMUX_PARITY_EN
      v = {2'(a), 2'(d), (^{2'(a), 2'(d)}) ^ bad};
`else
      v = {2'(a), 2'(d)};
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = PB-1; i >= 0; i--) send_bit(v[i]);
      if (pop_disp) begin
         rd_en = 1'b1;
         rd_ch = 2'(pch);
         if (m_n[pch] > 0) begin
            exp_q.push_back(2'(m_d[pch][0]));
            m_pop(pch);
         end
      end
      tick();
      rd_en = 1'b0;
      last_ovf = 1'b0;
      if (!bad) last_ovf = m_write(a, d);
      if (last_ovf) ovf_exp++;
      check("ovf_o", 128'(ovf_o), 128'(last_ovf));
      check("err_o", 128'(err_o), 128'(bad));
      check("busy_idle", 128'(busy_o), 128'(0));
   endtask

   task automatic pop(input int ch);
      bit ev;
      ev = (m_n[ch] > 0);
      if (ev) begin
         exp_q.push_back(2'(m_d[ch][0]));
         m_pop(ch);
      end
      rd_en = 1'b1;
      rd_ch = 2'(ch);
      tick();
      rd_en = 1'b0;
      check("rd_valid", 128'(rd_valid), 128'(ev));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of stimulus expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int c = 0; c < 4; c++) m_n[c] = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("rst_buf", 128'(buf_o), 128'(0));
      check("rst_cnt", 128'(count_o), 128'(0));
      check("rst_busy", 128'(busy_o), 128'(0));
      check("rst_rdv", 128'(rd_valid), 128'(0));
      check("rst_rdd", 128'(rd_data), 128'(0));
      check("rst_ovf", 128'(ovf_o), 128'(0));
      check("rst_err", 128'(err_o), 128'(0));

      // Strobes while idle do nothing.
      key1 = 1'b1; tick(); key1 = 1'b0; key0 = 1'b1; tick(); key0 = 1'b0;
      check("idle_busy", 128'(busy_o), 128'(0));
      check("idle_cnt", 128'(count_o), 128'(0));

      // Bits 0,1,1,0 -> ch1 data 2.
      send_pkt(1, 2, 1'b0, 1'b0, 0);
      check("p1_ch1cnt", 128'(count_o[5:3]), 128'(3'd1));
      check("p1_slot", 128'(buf_o[20:18]), 128'(3'b101));
      check_image("p1");

      // Seven packets into ch3: ovf only on the seventh.
      for (int i = 0; i < 7; i++) begin
         send_pkt(3, i % 4, 1'b0, 1'b0, 0);
         check("ch3_ovf", 128'(ovf_o), 128'(i == 6));
      end
      check("ch3_cnt", 128'(count_o[11:9]), 128'(3'd6));
      check("ch3_slot0", 128'(buf_o[56:54]), 128'(3'b011));
      check("ch3_slot5", 128'(buf_o[71:69]), 128'(3'b101));
      check_image("ch3");

      // Three writes to ch0, four pops.
      send_pkt(0, 3, 1'b0, 1'b0, 0);
      send_pkt(0, 2, 1'b0, 1'b0, 0);
      send_pkt(0, 1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 4; i++) pop(0);
      check("ch0_empty", 128'(count_o[2:0]), 128'(3'd0));
      check_image("pops");

      // Restart mid-packet.
      start = 1'b1; tick(); start = 1'b0;
      send_bit(1'b1);
      send_bit(1'b1);
      check("mid_busy", 128'(busy_o), 128'(1));
      send_pkt(0, 1, 1'b0, 1'b0, 0);
      check("rst_slot", 128'(buf_o[2:0]), 128'(3'b011));
      check("rst_ch3", 128'(count_o[11:9]), 128'(3'd6));
      check_image("restart");

      // Fill ch2, then pop ch2 in the dispatch cycle of another ch2 write.
      for (int i = 0; i < 6; i++) send_pkt(2, (i % 3) + 1, 1'b0, 1'b0, 0);
      send_pkt(2, 3, 1'b0, 1'b1, 2);
      check("same_ovf", 128'(ovf_o), 128'(0));
      check("same_cnt", 128'(count_o[8:6]), 128'(3'd6));
      check("same_s0", 128'(buf_o[38:36]), 128'(3'b101));
      check("same_s5", 128'(buf_o[53:51]), 128'(3'b111));
      check_image("same");

      // Pop ch3 while ch1 is written.
      send_pkt(1, 0, 1'b0, 1'b1, 3);
      check_image("diff");

      // Both-high and idle cycles inside a packet carry no bit: ch1 data 3.
      start = 1'b1; tick(); start = 1'b0;
      send_bit(1'b0);
      key0 = 1'b1; key1 = 1'b1; tick(); key0 = 1'b0; key1 = 1'b0;
      send_bit(1'b1);
      tick();
      send_bit(1'b1);
      send_bit(1'b1);
`ifdef SERIAL_DEMUX_PARITY_EN
      send_bit(1'b1);
`endif
      tick();
      last_ovf = m_write(1, 3);
      check("glitch_cnt", 128'(count_o[5:3]), 128'(3'd3));
      check_image("glitch");

`ifdef SERIAL_DEMUX_PARITY_EN
      send_pkt(1, 2, 1'b1, 1'b0, 0);
      check_image("par_bad");
      send_pkt(1, 2, 1'b0, 1'b0, 0);
      check_image("par_ok");
`endif

      // Reset during DISPATCH aborts the write and clears everything.
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < PB; i++) send_bit(1'b0);
      check("disp_busy", 128'(busy_o), 128'(1));
      rst_n = 1'b0;
      #2;
      for (int c = 0; c < 4; c++) m_n[c] = 0;
      check("ar_buf", 128'(buf_o), 128'(0));
      check("ar_cnt", 128'(count_o), 128'(0));
      check("ar_busy", 128'(busy_o), 128'(0));
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check_image("after_rst");

      check("sb_drained", 128'(exp_q.size()), 128'(0));
      check("ovf_total", 128'(ovf_seen), 128'(ovf_exp));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
